// File: rtl/rl_pair_scheduler_if.sv
// ---------------------------------------------------------------------------
// rl_pair_scheduler_if
// Bundles the scheduler's control and memory-facing signals.
//   slave  : the scheduler side (rl_pair_scheduler)
//   master : the environment side (particle memories, filters, controller)
// Signals:
//   start, home_count           pass request and home-cell particle count
//   nb_cell_count               count of the cell addressed by nb_cell_sel
//   back_pressure               per-filter almost-full
//   all_buffer_empty            all filter buffers drained
//   ref_base/ref_load/
//   ref_slot_valid              reference group load controls
//   nb_cell_sel/nb_rd_en/
//   nb_rd_addr                  neighbor memory read port
//   pair_valid, phase           evaluation-unit controls
//   busy, done                  pass status
// ---------------------------------------------------------------------------
interface rl_pair_scheduler_if #(
  parameter int NUM_FILTER     = 7,
  parameter int ADDR_WIDTH     = 7,
  parameter int CELL_SEL_WIDTH = 4
);
  logic                      start;
  logic [ADDR_WIDTH-1:0]     home_count;
  logic [ADDR_WIDTH-1:0]     nb_cell_count;
  logic [NUM_FILTER-1:0]     back_pressure;
  logic                      all_buffer_empty;
  logic [ADDR_WIDTH-1:0]     ref_base;
  logic                      ref_load;
  logic [NUM_FILTER-1:0]     ref_slot_valid;
  logic [CELL_SEL_WIDTH-1:0] nb_cell_sel;
  logic                      nb_rd_en;
  logic [ADDR_WIDTH-1:0]     nb_rd_addr;
  logic [NUM_FILTER-1:0]     pair_valid;
  logic                      phase;
  logic                      busy;
  logic                      done;

  modport slave (
    input  start, home_count, nb_cell_count, back_pressure, all_buffer_empty,
    output ref_base, ref_load, ref_slot_valid, nb_cell_sel, nb_rd_en,
           nb_rd_addr, pair_valid, phase, busy, done
  );

  modport master (
    output start, home_count, nb_cell_count, back_pressure, all_buffer_empty,
    input  ref_base, ref_load, ref_slot_valid, nb_cell_sel, nb_rd_en,
           nb_rd_addr, pair_valid, phase, busy, done
  );
endinterface

// File: rtl/rl_pair_scheduler.sv
// ---------------------------------------------------------------------------
// rl_pair_scheduler
// Half-shell pair sequencer for the range-limited LJ evaluation unit. Loads
// groups of NUM_FILTER home-cell reference particles, streams every particle
// of each half-shell cell (cell 0 = home) past them, and waits for the filter
// buffers to drain before the next group.
// Ports:
//   clk    clock
//   rst    synchronous active-high reset (aborts a pass, no done pulse)
//   sched  rl_pair_scheduler_if.slave (see interface header)
// Build option:
//   RL_SCHED_HOME_HALF_EN  when defined, home-cell pairs are masked for
//                          nb address <= ref_base+i so each home pair is
//                          evaluated once; otherwise only self-pairs are masked.
// nb_rd_en is decided combinationally so back-pressure stalls the very cycle
// it is raised; all other outputs are registered.
// ---------------------------------------------------------------------------
module rl_pair_scheduler #(
  parameter int NUM_FILTER     = 7,
  parameter int ADDR_WIDTH     = 7,
  parameter int NUM_NB_CELLS   = 14,
  parameter int CELL_SEL_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  rl_pair_scheduler_if.slave sched
);
  localparam int BW = ADDR_WIDTH + 1;
  localparam logic [CELL_SEL_WIDTH-1:0] LAST_CELL  = CELL_SEL_WIDTH'(NUM_NB_CELLS - 1);
  localparam logic [BW-1:0]             GROUP_STEP = BW'(NUM_FILTER);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_REF = 3'd1,
    S_ISSUE    = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                    state_r, state_s;
  logic [BW-1:0]             ref_base_r, base_next_s, load_base_s;
  logic [ADDR_WIDTH-1:0]     home_count_r, load_count_s;
  logic [NUM_FILTER-1:0]     ref_slot_valid_r, pair_valid_r, pair_mask_s, home_mask_s;
  logic [CELL_SEL_WIDTH-1:0] cell_r;
  logic [ADDR_WIDTH-1:0]     addr_r;
  logic                      ref_load_r, phase_r, busy_r, done_r;
  logic                      stall_s, cell_empty_s, last_addr_s, last_cell_s;
  logic                      rd_en_s, cell_adv_s, drained_s, accept_s, group_end_s;

  // Slot i holds a real particle only while base+i is inside the home cell.
  function automatic logic [NUM_FILTER-1:0] slot_valid_f(input logic [BW-1:0] base,
                                                        input logic [ADDR_WIDTH-1:0] count);
    logic [NUM_FILTER-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
      v[i] = ((base + BW'(i)) < {1'b0, count});
    end
    return v;
  endfunction

  // Home-cell pairs suppressed for the particle at addr against slot base+i.
  function automatic logic [NUM_FILTER-1:0] home_mask_f(input logic [BW-1:0] base,
                                                       input logic [ADDR_WIDTH-1:0] addr);
    logic [NUM_FILTER-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
`ifdef RL_SCHED_HOME_HALF_EN
      m[i] = ({1'b0, addr} <= (base + BW'(i)));
`else
      m[i] = ({1'b0, addr} == (base + BW'(i)));
`endif
    end
    return m;
  endfunction

  assign stall_s      = |sched.back_pressure;
  assign cell_empty_s = (sched.nb_cell_count == '0);
  assign last_addr_s  = (addr_r >= (sched.nb_cell_count - ADDR_WIDTH'(1)));
  assign last_cell_s  = (cell_r >= LAST_CELL);
  assign rd_en_s      = (state_r == S_ISSUE) && !cell_empty_s && !stall_s;
  // An empty cell is skipped in one cycle regardless of back-pressure.
  assign cell_adv_s   = (state_r == S_ISSUE) && (cell_empty_s || (rd_en_s && last_addr_s));
  assign drained_s    = (pair_valid_r == '0) && sched.all_buffer_empty;
  assign accept_s     = (state_r == S_IDLE) && sched.start;
  assign group_end_s  = (state_r == S_DRAIN) && drained_s;
  // Extra bit keeps the final group's overflow from wrapping back below home_count.
  assign base_next_s  = ref_base_r + GROUP_STEP;
  assign load_base_s  = accept_s ? '0 : base_next_s;
  assign load_count_s = accept_s ? sched.home_count : home_count_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (sched.start) begin
          state_s = (sched.home_count == '0) ? S_DONE : S_LOAD_REF;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD_REF: state_s = S_ISSUE;
      S_ISSUE: begin
        if (cell_adv_s && last_cell_s) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (drained_s) begin
          state_s = (base_next_s >= {1'b0, home_count_r}) ? S_DONE : S_LOAD_REF;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Self-pair (or lower-triangle) suppression applies only inside the home cell.
  always_comb begin
    home_mask_s = '0;
    if (cell_r == '0) begin
      home_mask_s = home_mask_f(ref_base_r, addr_r);
    end else begin
      home_mask_s = '0;
    end
  end

  assign pair_mask_s = {NUM_FILTER{rd_en_s}} & ref_slot_valid_r & ~home_mask_s;

  // Group/cell/address counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_base_r       <= '0;
      home_count_r     <= '0;
      ref_slot_valid_r <= '0;
      cell_r           <= '0;
      addr_r           <= '0;
      pair_valid_r     <= '0;
      ref_load_r       <= 1'b0;
      phase_r          <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
    end else begin
      ref_load_r   <= (state_s == S_LOAD_REF);
      busy_r       <= (state_s != S_IDLE);
      done_r       <= (state_s == S_DONE);
      // Registered one cycle after the read so it lines up with memory data.
      pair_valid_r <= pair_mask_s;
      if (accept_s) begin
        home_count_r <= sched.home_count;
        ref_base_r   <= '0;
      end else if (group_end_s) begin
        ref_base_r <= base_next_s;
      end
      if (state_s == S_LOAD_REF) begin
        phase_r          <= ~phase_r;
        ref_slot_valid_r <= slot_valid_f(load_base_s, load_count_s);
        cell_r           <= '0;
        addr_r           <= '0;
      end else if (cell_adv_s) begin
        addr_r <= '0;
        cell_r <= last_cell_s ? '0 : cell_r + CELL_SEL_WIDTH'(1);
      end else if (rd_en_s) begin
        addr_r <= addr_r + ADDR_WIDTH'(1);
      end
    end
  end

  assign sched.ref_base       = ref_base_r[ADDR_WIDTH-1:0];
  assign sched.ref_load       = ref_load_r;
  assign sched.ref_slot_valid = ref_slot_valid_r;
  assign sched.nb_cell_sel    = cell_r;
  assign sched.nb_rd_en       = rd_en_s;
  assign sched.nb_rd_addr     = addr_r;
  assign sched.pair_valid     = pair_valid_r;
  assign sched.phase          = phase_r;
  assign sched.busy           = busy_r;
  assign sched.done           = done_r;
endmodule

// File: tb/tb_rl_pair_scheduler.sv
// Self-checking bench for rl_pair_scheduler: expected reads, pair masks and
// group loads are queued from a small model before each pass and popped as
// the DUT produces them.
module tb_rl_pair_scheduler;
  localparam int NF = 7;
  localparam int AW = 7;
  localparam int NC = 14;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   exp_phase = 1'b0;
  logic [AW-1:0] cell_cnt [16];

  always #5 clk = ~clk;

  rl_pair_scheduler_if #(.NUM_FILTER(NF), .ADDR_WIDTH(AW), .CELL_SEL_WIDTH(CW)) sched_if ();

  rl_pair_scheduler #(
    .NUM_FILTER(NF), .ADDR_WIDTH(AW), .NUM_NB_CELLS(NC), .CELL_SEL_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sched (sched_if)
  );

  assign sched_if.nb_cell_count = cell_cnt[sched_if.nb_cell_sel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cells(input int v);
    for (int c = 0; c < 16; c++) cell_cnt[c] = (c < NC) ? 7'(v) : 7'd0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ref_base"}, sched_if.ref_base, 0);
    chk({tag, "_ref_load"}, sched_if.ref_load, 0);
    chk({tag, "_slot_valid"}, sched_if.ref_slot_valid, 0);
    chk({tag, "_cell_sel"}, sched_if.nb_cell_sel, 0);
    chk({tag, "_rd_en"}, sched_if.nb_rd_en, 0);
    chk({tag, "_rd_addr"}, sched_if.nb_rd_addr, 0);
    chk({tag, "_pair_valid"}, sched_if.pair_valid, 0);
    chk({tag, "_phase"}, sched_if.phase, 0);
    chk({tag, "_busy"}, sched_if.busy, 0);
    chk({tag, "_done"}, sched_if.done, 0);
  endtask

  // One complete pass with optional back-pressure window, drain hold and a
  // start pulse while busy. Negative arguments disable those features.
  task automatic run_pass(input int home, input int stall_after, input int stall_len,
                          input int hold_after, input int extra_start_at);
    logic [11:0] issue_q[$];
    logic [6:0]  pv_q[$];
    logic [13:0] load_q[$];
    int          len_q[$];
    int groups, reads_exp, reads_seen, loads_seen, dones_seen, last_load, cur_len;
    int frozen, bp_left, hold_left, entries, issue_left, base;
    bit prev_rd, finished, rise_pend, load_pend, stall_used, hold_used;
    bit stalled_now, hold_now, rise_now, load_now, check_len;
    logic [6:0]  slot, pv;
    logic [11:0] e;
    logic [13:0] le;

    groups = (home + NF - 1) / NF;
    reads_exp = 0;
    for (int g = 0; g < groups; g++) begin
      base = g * NF;
      slot = '0;
      for (int i = 0; i < NF; i++) slot[i] = (base + i < home);
      load_q.push_back({7'(base), slot});
      entries = 0;
      for (int c = 0; c < NC; c++) begin
        if (cell_cnt[c] == 7'd0) begin
          issue_q.push_back({4'(c), 1'b0, 7'd0});
          entries++;
        end else begin
          for (int a = 0; a < int'(cell_cnt[c]); a++) begin
            issue_q.push_back({4'(c), 1'b1, 7'(a)});
            entries++;
            reads_exp++;
            pv = slot;
            if (c == 0) begin
              for (int i = 0; i < NF; i++) begin
`ifdef RL_SCHED_HOME_HALF_EN
                if (a <= base + i) pv[i] = 1'b0;
`else
                if (a == base + i) pv[i] = 1'b0;
`endif
              end
            end
            pv_q.push_back(pv);
          end
        end
      end
      len_q.push_back(entries);
    end

    check_len = (stall_len == 0) && (hold_after < 0);
    reads_seen = 0; loads_seen = 0; dones_seen = 0; last_load = -1; cur_len = 0;
    frozen = 0; bp_left = 0; hold_left = 0; issue_left = 0;
    prev_rd = 0; finished = 0; rise_pend = 0; load_pend = 0; stall_used = 0; hold_used = 0;

    @(posedge clk); #1;
    sched_if.home_count = 7'(home);
    sched_if.start = 1'b1;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(posedge clk); #1;
      sched_if.start = (cyc == extra_start_at);
      sched_if.home_count = (cyc == extra_start_at) ? 7'd1 : 7'(home);
      stalled_now = (bp_left > 0);
      hold_now = (hold_left > 0);
      rise_now = rise_pend;
      load_now = load_pend;
      rise_pend = 0;
      load_pend = 0;
      sched_if.back_pressure = stalled_now ? 7'b0001000 : 7'b0000000;
      sched_if.all_buffer_empty = !hold_now;
      #1;
      if (prev_rd) begin
        if (pv_q.size() > 0) chk("pair_valid", sched_if.pair_valid, pv_q.pop_front());
        else chk("pair_valid_queue", pv_q.size(), 1);
      end else begin
        chk("pair_valid_idle", sched_if.pair_valid, 0);
      end
      prev_rd = sched_if.nb_rd_en;
      if (sched_if.nb_rd_en) reads_seen++;
      if (hold_now || rise_now) begin
        chk("drain_hold_no_load", sched_if.ref_load, 0);
        chk("drain_hold_busy", sched_if.busy, 1);
      end
      if (load_now) chk("load_after_rise", sched_if.ref_load, 1);
      if (sched_if.ref_load) begin
        loads_seen++;
        if (check_len && last_load >= 0) chk("group_cycles", cyc - last_load, cur_len + 3);
        last_load = cyc;
        exp_phase = ~exp_phase;
        chk("phase", sched_if.phase, exp_phase);
        chk("load_cell_sel", sched_if.nb_cell_sel, 0);
        chk("load_rd_en", sched_if.nb_rd_en, 0);
        if (load_q.size() > 0) begin
          le = load_q.pop_front();
          chk("ref_base", sched_if.ref_base, le[13:7]);
          chk("ref_slot_valid", sched_if.ref_slot_valid, le[6:0]);
          cur_len = len_q.pop_front();
          issue_left = cur_len;
        end else begin
          chk("unexpected_ref_load", loads_seen, groups);
        end
      end else if (issue_left > 0 && !stalled_now) begin
        e = issue_q.pop_front();
        issue_left--;
        chk("nb_cell_sel", sched_if.nb_cell_sel, e[11:8]);
        chk("nb_rd_en", sched_if.nb_rd_en, e[7]);
        if (e[7]) chk("nb_rd_addr", sched_if.nb_rd_addr, e[6:0]);
      end else begin
        chk("no_read", sched_if.nb_rd_en, 0);
        if (stalled_now && issue_q.size() > 0) begin
          e = issue_q[0];
          chk("stall_cell_sel", sched_if.nb_cell_sel, e[11:8]);
          chk("stall_rd_addr", sched_if.nb_rd_addr, e[6:0]);
          if (sched_if.nb_rd_addr == e[6:0] && !sched_if.nb_rd_en) frozen++;
        end
      end
      if (sched_if.done) begin
        dones_seen++;
        finished = 1;
        if (check_len && last_load >= 0) chk("done_cycles", cyc - last_load, cur_len + 3);
      end
      if (stalled_now) bp_left--;
      if (hold_now) begin
        hold_left--;
        if (hold_left == 0) rise_pend = 1;
      end
      if (rise_now) load_pend = 1;
      if (!stall_used && stall_len > 0 && sched_if.nb_rd_en && reads_seen == stall_after) begin
        bp_left = stall_len;
        stall_used = 1;
      end
      if (!hold_used && hold_after >= 0 && sched_if.nb_rd_en && reads_seen == hold_after) begin
        hold_left = 20;
        hold_used = 1;
      end
    end
    sched_if.back_pressure = 7'b0000000;
    sched_if.all_buffer_empty = 1'b1;
    sched_if.start = 1'b0;
    chk("pass_finished", finished, 1);
    chk("read_count", reads_seen, reads_exp);
    chk("load_count", loads_seen, groups);
    chk("done_count", dones_seen, 1);
    chk("issue_queue_left", issue_q.size(), 0);
    chk("pv_queue_left", pv_q.size(), 0);
    chk("phase_end", sched_if.phase, exp_phase);
    if (stall_len > 0) chk("frozen_cycles", frozen, stall_len);
    tick();
    chk("done_single_cycle", sched_if.done, 0);
    chk("idle_not_busy", sched_if.busy, 0);
  endtask

  initial begin
    int stray_done;
    rst = 1'b1;
    sched_if.start = 1'b0;
    sched_if.home_count = 7'd0;
    sched_if.back_pressure = 7'b0000000;
    sched_if.all_buffer_empty = 1'b1;
    set_cells(3);
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // Two groups, 42 reads each, with a start pulse while busy that must be ignored.
    set_cells(3);
    run_pass(10, -1, 0, -1, 20);
    chk("two_group_phase_zero", sched_if.phase, 0);

    // back_pressure[3] for 5 cycles in the middle of cell 1.
    run_pass(7, 4, 5, -1, -1);

    // Empty cells 2 and 5 take one cycle each.
    set_cells(2);
    cell_cnt[2] = 7'd0;
    cell_cnt[5] = 7'd0;
    run_pass(7, -1, 0, -1, -1);

    // Home-cell masking with 4 home particles.
    set_cells(1);
    cell_cnt[0] = 7'd4;
    run_pass(4, -1, 0, -1, -1);

    // all_buffer_empty low for 20 cycles after the first group's last read.
    set_cells(3);
    run_pass(10, -1, 0, 42, -1);

    // Empty home cell: straight to done.
    run_pass(0, -1, 0, -1, -1);

    // Reset in the middle of ISSUE aborts the pass.
    set_cells(3);
    sched_if.home_count = 7'd7;
    sched_if.start = 1'b1;
    tick();
    sched_if.start = 1'b0;
    repeat (5) tick();
    chk("mid_pass_busy", sched_if.busy, 1);
    chk("mid_pass_reading", sched_if.nb_rd_en, 1);
    rst = 1'b1;
    tick();
    check_reset("reset_mid_pass");
    rst = 1'b0;
    exp_phase = 1'b0;
    stray_done = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (sched_if.done || sched_if.busy) stray_done++;
    end
    chk("no_activity_after_abort", stray_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/rl_pair_scheduler.md
# rl_pair_scheduler

Sequencer for the range-limited LJ evaluation unit under the half-shell mapping. It loads groups of NUM_FILTER reference particles from the home cell, then streams every particle of each half-shell neighbor cell past them. It raises per-filter pair_valid, honours filter back-pressure, and waits for the filter buffers to drain before moving to the next reference group. It sits between the home/neighbor particle memories and the evaluation unit, and drives that unit's phase input.

## Interface
Parameters:
- NUM_FILTER, 7, number of filters and reference slots per group.
- ADDR_WIDTH, 7, particle-in-cell address width.
- NUM_NB_CELLS, 14, number of half-shell cells, including the home cell. Cell index 0 is the home cell.
- CELL_SEL_WIDTH, 4, width of the neighbor cell select.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a home-cell pass. It is ignored unless the FSM is in IDLE.
- home_count  in  ADDR_WIDTH  number of particles in the home cell, sampled on an accepted start.
- nb_cell_count  in  ADDR_WIDTH  particle count of the cell selected by nb_cell_sel. This input is combinational from the cell-count table.
- back_pressure  in  NUM_FILTER  per-filter almost-full. Any set bit stalls issue.
- all_buffer_empty  in  1  all filter buffers are empty.
- ref_base  out  ADDR_WIDTH  home-cell address of reference slot 0. Slot i is ref_base+i.
- ref_load  out  1  one-cycle strobe that latches NUM_FILTER reference positions.
- ref_slot_valid  out  NUM_FILTER  bit i is set when ref_base+i < home_count. Held for the whole group.
- nb_cell_sel  out  CELL_SEL_WIDTH  current neighbor cell.
- nb_rd_en  out  1  neighbor memory read strobe. Memory read latency is 1 cycle.
- nb_rd_addr  out  ADDR_WIDTH  neighbor read address.
- pair_valid  out  NUM_FILTER  per-filter pair valid, aligned with the read data.
- phase  out  1  evaluation-unit phase. Toggles on every ref_load.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a pass.

## Operation
States: IDLE, LOAD_REF, ISSUE, DRAIN, DONE.
- IDLE
  - start with home_count==0 goes to DONE.
  - start with home_count>0 goes to LOAD_REF, with ref_base=0.
- LOAD_REF: lasts one cycle.
  - ref_load=1 and phase toggles.
  - nb_cell_sel=0 and the neighbor address counter is cleared.
  - Next state is ISSUE.
- ISSUE: the stall condition is |back_pressure.
  - If nb_cell_count==0, the FSM advances to the next cell in one cycle with no read.
  - Otherwise, each non-stalled cycle issues nb_rd_en=1 at the current address, then increments the address.
  - After the read at address count-1, the address returns to 0 and the cell index increments.
  - After the last cell (NUM_NB_CELLS-1), the next state is DRAIN.
- DRAIN: waits until the registered pair_valid is 0 and all_buffer_empty==1 on the same cycle. Then ref_base += NUM_FILTER.
  - If ref_base >= home_count, go to DONE.
  - Otherwise go to LOAD_REF.
- DONE: done=1 for one cycle, then IDLE.
- Pair masking: pair_valid[i] = registered nb_rd_en AND ref_slot_valid[i]. In the home cell (cell 0), bit i is also masked when nb address == ref_base+i, so a particle is never paired with itself.
- ref_base arithmetic is ADDR_WIDTH+1 bits internally, so the final group's overflow past 2^ADDR_WIDTH-1 ends the pass and does not wrap.
- Reset mid-operation aborts the pass: state goes to IDLE and no done pulse is produced.
- A start pulse that arrives while busy is dropped and has no side effects.

## Timing
- Reset values:
  - state=IDLE.
  - ref_base=0, ref_load=0, ref_slot_valid=0.
  - nb_cell_sel=0, nb_rd_en=0, nb_rd_addr=0.
  - pair_valid=0, phase=0, busy=0, done=0.
- From start to the first ref_load is 1 cycle. The first nb_rd_en follows ref_load by 1 cycle.
- pair_valid is registered, 1 cycle after nb_rd_en. It lines up with the memory data.
- Back-pressure is evaluated in the same cycle; the filters guarantee at least 2 entries of slack.
- Stalls do not change nb_rd_addr or nb_cell_sel.
- The minimum cycle count per group with no stalls is 1 + ΣN_c + (number of empty cells) + 2, where ΣN_c is the sum of the neighbor cell counts.

## Configuration
- RL_SCHED_HOME_HALF_EN defined: in the home cell, pair_valid[i] is also masked when nb address <= ref_base+i. Each home pair is then evaluated once.
- RL_SCHED_HOME_HALF_EN undefined: only the self-pair is masked. Each home pair appears twice, and downstream logic discards the neighbor-side home force.

## Test plan
- home_count=10, all 14 cells with 3 particles, no back-pressure. Expect:
  - 2 groups: ref_load at base 0 and 7.
  - ref_slot_valid=0x7F, then 0x07.
  - 42 reads per group, phase ends at 0, done pulses once.
- home_count=7, back_pressure[3] held for 5 cycles mid-cell. Expect:
  - nb_rd_addr frozen for exactly 5 cycles.
  - No read is lost or duplicated, and the total read count is unchanged.
- Cells 2 and 5 have count 0, all other cells have count 2. Expect each empty cell to take exactly one cycle with no nb_rd_en, and nb_cell_sel to step through 0..13.
- home_count=4, home cell count 4. With the macro defined, home-cell pair_valid bits across reads 0..3 are 0x0, 0x1, 0x3, 0x7. Without the macro they are 0xE, 0xD, 0xB, 0x7.
- all_buffer_empty held low for 20 cycles after the last read. Expect the FSM to stay in DRAIN, with ref_load following exactly one cycle after the input rises.
- Three further cases:
  - rst asserted during ISSUE: all outputs are at their reset values the next cycle.
  - start with home_count=0: done the cycle after the FSM leaves IDLE, with no reads.
  - start while busy: ignored.
